obstacle_control: RTL and testbench

OBSTACLE_CONTROL -- requirements
Module: obstacle_control

---
 rtl/game_pkg.sv | 25 ++
 rtl/spawn_lfsr10.sv | 23 ++
 rtl/obstacle_control.sv | 151 +++++++++++++++
 tb/tb_obstacle_control.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game definitions: FSM encodings, playfield limits, reset constants, spawn mapping.
// Latency: none (declarations only).  Backpressure: not applicable.
package game_pkg;

    typedef enum logic [2:0] {
        ST_SPAWN = 3'd0,
        ST_FALL  = 3'd1,
        ST_CATCH = 3'd2,
        ST_MISS  = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam logic [9:0] MAX_X         = 10'd639;
    localparam logic [9:0] BOX_WIDTH_DEF = 10'd30;
    localparam logic [9:0] LFSR_SEED     = 10'h1A5;
    localparam logic [9:0] OBJ_X_RST     = 10'd312;

    // Values that would push the object past the right edge fold back by 512.
    function automatic logic [9:0] spawn_x(input logic [9:0] lfsr, input logic [9:0] obj_size);
        logic [9:0] lim;
        lim = MAX_X + 10'd1 - obj_size;
        return (lfsr > lim) ? (lfsr - 10'd512) : lfsr;
    endfunction

endpackage

// File: rtl/spawn_lfsr10.sv
// Free-running 10-bit Fibonacci LFSR (x^10 + x^7 + 1) used to pick spawn columns.
// Latency: advances every clk regardless of game tick.  Backpressure: none.
module spawn_lfsr10
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] q
);

    logic [9:0] r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= LFSR_SEED;
        end else begin
            r_q <= {r_q[8:0], r_q[9] ^ r_q[6]};
        end
    end

    assign q = r_q;

endmodule

// File: rtl/obstacle_control.sv
// Falling-object game FSM: spawn, fall, catch/miss scoring, lives and game over.
// Latency: one game_en tick per state step; optional speedup via OBSTACLE_SPEEDUP_EN.
// Backpressure: none; game_en acts as the only advance strobe, OVER waits for reset.
module obstacle_control
    import game_pkg::*;
#(
    parameter logic [9:0] BOX_WIDTH = BOX_WIDTH_DEF,
    parameter logic [9:0] BOX_Y     = 10'd440,
    parameter logic [9:0] OBJ_SIZE  = 10'd16,
    parameter logic [9:0] FALL_STEP = 10'd4,
    parameter logic [1:0] MAX_LIVES = 2'd3
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       game_en,
    input  logic [9:0] box_x,
    output logic [9:0] obj_x,
    output logic [9:0] obj_y,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic       catch_pulse,
    output logic       miss_pulse,
    output logic       game_over
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [9:0] r_obj_x;
    logic [9:0] r_obj_y;
    logic [7:0] r_score;
    logic [1:0] r_lives;
    logic       r_catch_pulse;
    logic       r_miss_pulse;

    logic [9:0] w_obj_x_nxt;
    logic [9:0] w_obj_y_nxt;
    logic [7:0] w_score_nxt;
    logic [1:0] w_lives_nxt;
    logic       w_catch_nxt;
    logic       w_miss_nxt;

    logic [9:0] w_lfsr;
    logic [9:0] w_step;
    logic [9:0] w_obj_bottom;
    logic [9:0] w_obj_right;
    logic [9:0] w_box_right;
    logic       w_at_bottom;
    logic       w_overlap;
    logic [1:0] w_lives_dec;

    spawn_lfsr10 u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (w_lfsr)
    );

`ifdef OBSTACLE_SPEEDUP_EN
    logic [9:0] w_step_raw;
    logic [9:0] w_step_cap;
    assign w_step_raw = FALL_STEP + {5'd0, r_score[7:3]};
    assign w_step_cap = FALL_STEP << 1;
    assign w_step     = (w_step_raw > w_step_cap) ? w_step_cap : w_step_raw;
`else
    assign w_step = FALL_STEP;
`endif

    // Bottom test uses the current obj_y; box_x only matters on this tick.
    assign w_obj_bottom = r_obj_y + OBJ_SIZE;
    assign w_obj_right  = r_obj_x + OBJ_SIZE;
    assign w_box_right  = box_x + BOX_WIDTH;
    assign w_at_bottom  = (w_obj_bottom >= BOX_Y);
    assign w_overlap    = (w_obj_right > box_x) && (r_obj_x < w_box_right);
    assign w_lives_dec  = r_lives - 2'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_SPAWN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_obj_x_nxt = r_obj_x;
        w_obj_y_nxt = r_obj_y;
        w_score_nxt = r_score;
        w_lives_nxt = r_lives;
        w_catch_nxt = 1'b0;
        w_miss_nxt  = 1'b0;
        if (game_en) begin
            case (r_state)
                ST_SPAWN: begin
                    w_obj_x_nxt = spawn_x(w_lfsr, OBJ_SIZE);
                    w_obj_y_nxt = 10'd0;
                    w_state_nxt = ST_FALL;
                end
                ST_FALL: begin
                    if (w_at_bottom) begin
                        w_state_nxt = w_overlap ? ST_CATCH : ST_MISS;
                    end else begin
                        w_obj_y_nxt = r_obj_y + w_step;
                    end
                end
                ST_CATCH: begin
                    w_score_nxt = (r_score == 8'hFF) ? r_score : (r_score + 8'd1);
                    w_catch_nxt = 1'b1;
                    w_state_nxt = ST_SPAWN;
                end
                ST_MISS: begin
                    w_lives_nxt = w_lives_dec;
                    w_miss_nxt  = 1'b1;
                    w_state_nxt = (w_lives_dec == 2'd0) ? ST_OVER : ST_SPAWN;
                end
                ST_OVER: begin
                    w_state_nxt = ST_OVER;
                end
                default: begin
                    w_state_nxt = ST_SPAWN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_obj_x       <= OBJ_X_RST;
            r_obj_y       <= 10'd0;
            r_score       <= 8'd0;
            r_lives       <= MAX_LIVES;
            r_catch_pulse <= 1'b0;
            r_miss_pulse  <= 1'b0;
        end else begin
            r_obj_x       <= w_obj_x_nxt;
            r_obj_y       <= w_obj_y_nxt;
            r_score       <= w_score_nxt;
            r_lives       <= w_lives_nxt;
            r_catch_pulse <= w_catch_nxt;
            r_miss_pulse  <= w_miss_nxt;
        end
    end

    assign obj_x       = r_obj_x;
    assign obj_y       = r_obj_y;
    assign score       = r_score;
    assign lives       = r_lives;
    assign catch_pulse = r_catch_pulse;
    assign miss_pulse  = r_miss_pulse;
    assign game_over   = (r_state == ST_OVER);

endmodule

// File: tb/tb_obstacle_control.sv
// Directed bench for obstacle_control: reset, spawn mapping, catch/miss edges, game over.
// Spawn columns are chosen by waiting until an independent LFSR model holds the target.
module tb_obstacle_control;

    logic       clk;
    logic       rst;
    logic       game_en;
    logic [9:0] box_x;
    logic [9:0] obj_x;
    logic [9:0] obj_y;
    logic [7:0] score;
    logic [1:0] lives;
    logic       catch_pulse;
    logic       miss_pulse;
    logic       game_over;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_score;
    int exp_lives;
    logic [9:0] m_lfsr;

    obstacle_control dut (
        .clk         (clk),
        .rst         (rst),
        .game_en     (game_en),
        .box_x       (box_x),
        .obj_x       (obj_x),
        .obj_y       (obj_y),
        .score       (score),
        .lives       (lives),
        .catch_pulse (catch_pulse),
        .miss_pulse  (miss_pulse),
        .game_over   (game_over)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference LFSR: x^10 + x^7 + 1, seed 0x1A5, runs every clock.
    always @(posedge clk or negedge rst) begin
        if (!rst) m_lfsr <= 10'h1A5;
        else      m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        game_en = 1'b1;
        @(negedge clk);
        game_en = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_obj_x"}, 32'(obj_x), 32'd312);
        chk({tag, "_obj_y"}, 32'(obj_y), 32'd0);
        chk({tag, "_score"}, 32'(score), 32'd0);
        chk({tag, "_lives"}, 32'(lives), 32'd3);
        chk({tag, "_game_over"}, 32'(game_over), 32'd0);
        chk({tag, "_catch_pulse"}, 32'(catch_pulse), 32'd0);
        chk({tag, "_miss_pulse"}, 32'(miss_pulse), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        chk_reset_vals(tag);
        @(negedge clk);
        rst = 1'b1;
        exp_score = 0;
        exp_lives = 3;
    endtask

    // Idle until the LFSR holds the target, then issue the SPAWN tick.
    task automatic spawn_at(input logic [9:0] target);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            if (m_lfsr == target) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("spawn_wait_found", 32'(found), 32'd1);
        tick();
    endtask

    task automatic run_drop(input logic [9:0] target, input logic [9:0] exp_x,
                            input logic [9:0] bx, input bit exp_catch);
        spawn_at(target);
        chk("drop_spawn_obj_x", 32'(obj_x), 32'(exp_x));
        chk("drop_spawn_obj_y", 32'(obj_y), 32'd0);
        for (int i = 0; i < 106; i++) begin
            box_x = 10'($urandom_range(0, 610));
            tick();
        end
        chk("drop_bottom_obj_y", 32'(obj_y), 32'd424);
        box_x = bx;
        tick();
        chk("drop_decide_obj_y", 32'(obj_y), 32'd424);
        chk("drop_decide_score", 32'(score), 32'(exp_score));
        chk("drop_decide_lives", 32'(lives), 32'(exp_lives));
        box_x = 10'($urandom_range(0, 610));
        tick();
        if (exp_catch) exp_score++;
        else           exp_lives--;
        chk("drop_result_score", 32'(score), 32'(exp_score));
        chk("drop_result_lives", 32'(lives), 32'(exp_lives));
        chk("drop_catch_pulse", 32'(catch_pulse), 32'(exp_catch));
        chk("drop_miss_pulse", 32'(miss_pulse), 32'(!exp_catch));
        chk("drop_game_over", 32'(game_over), 32'(exp_lives == 0));
        @(negedge clk);
        chk("drop_catch_pulse_clear", 32'(catch_pulse), 32'd0);
        chk("drop_miss_pulse_clear", 32'(miss_pulse), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        game_en   = 1'b0;
        box_x     = 10'd0;
        exp_score = 0;
        exp_lives = 3;
        @(negedge clk);
        do_reset("reset");

        // Spawn mapping: 700 folds to 188, 300 passes through.
        spawn_at(10'd700);
        chk("map700_obj_x", 32'(obj_x), 32'd188);
        chk("map700_obj_y", 32'(obj_y), 32'd0);
        tick();
        tick();
        chk("midfall_obj_y", 32'(obj_y), 32'd8);
        do_reset("reset_midfall");
        spawn_at(10'd300);
        chk("map300_obj_x", 32'(obj_x), 32'd300);
        do_reset("reset_after_map");

        // Catches and overlap edges against box_x = 90.
        run_drop(10'd100, 10'd100, 10'd90, 1'b1);
        run_drop(10'd75,  10'd75,  10'd90, 1'b1);
        run_drop(10'd119, 10'd119, 10'd90, 1'b1);
        run_drop(10'd74,  10'd74,  10'd90, 1'b0);
        run_drop(10'd120, 10'd120, 10'd90, 1'b0);
        chk("edges_score", 32'(score), 32'd3);
        chk("edges_lives", 32'(lives), 32'd1);
        do_reset("reset_after_edges");

        // Three consecutive misses end the game.
        run_drop(10'd500, 10'd500, 10'd100, 1'b0);
        run_drop(10'd200, 10'd200, 10'd500, 1'b0);
        run_drop(10'd50,  10'd50,  10'd400, 1'b0);
        for (int i = 0; i < 20; i++) begin
            box_x = 10'($urandom_range(0, 610));
            tick();
        end
        chk("over_obj_x", 32'(obj_x), 32'd50);
        chk("over_obj_y", 32'(obj_y), 32'd424);
        chk("over_score", 32'(score), 32'd0);
        chk("over_lives", 32'(lives), 32'd0);
        chk("over_game_over", 32'(game_over), 32'd1);
        chk("over_catch_pulse", 32'(catch_pulse), 32'd0);
        chk("over_miss_pulse", 32'(miss_pulse), 32'd0);
        do_reset("reset_after_over");
        @(negedge clk);
        chk("post_reset_game_over", 32'(game_over), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
